// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC and the F/D register, with delay-slot redirect via next_pc.
// Optional fetch address checking is built when FETCH_EXC_EN is defined.
module stage_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef FETCH_EXC_EN
  ,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        fetch_busy,
  output logic        exc_d
);

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pcd_q, instr_q;
  logic        valid_q;
  logic        illegal;
  logic        live;
  logic        ready_eff;
  logic        adv;

`ifdef FETCH_EXC_EN
  localparam logic [31:0] IMEM_LIMIT =
    IMEM_BASE + 32'(IMEM_WORDS * 4);

  assign illegal = (pc_q[1:0] != 2'b00)
                 | (pc_q < IMEM_BASE)
                 | (pc_q >= IMEM_LIMIT);
`else
  assign illegal = 1'b0;
`endif

  // Illegal fetches never touch memory, so they complete at once.
  assign live      = (state_q != S_RST);
  assign ready_eff = illegal | imem_ready;
  assign adv       = live & ready_eff & ~stall;

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    fetch_busy = 1'b0;
    unique case (state_q)
      S_RST: begin
        state_d = S_RUN;
      end
      S_RUN, S_WAIT: begin
        imem_req   = ~illegal;
        fetch_busy = ~ready_eff;
        state_d    = ready_eff ? S_RUN : S_WAIT;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      pcd_q   <= 32'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else if (adv) begin
      pc_q    <= next_pc;
      pcd_q   <= pc_q;
      instr_q <= illegal ? 32'h0 : imem_rdata;
      valid_q <= 1'b1;
    end
  end

`ifdef FETCH_EXC_EN
  logic exc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exc_q <= 1'b0;
    end else if (adv) begin
      exc_q <= illegal;
    end
  end

  assign exc_d = exc_q;
`else
  assign exc_d = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign pc_f      = pc_q;
  assign pc_d      = pcd_q;
  assign instr_d   = instr_q;
  assign valid_d   = valid_q;

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed test-plan steps then random traffic,
// checked against a cycle-level reference model of the fetch stage.
module tb_stage_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] LIMIT  = 32'h0000_3000 + 32'd16384;
  localparam logic [31:0] KEY    = 32'hC0DE_0000;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_f;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        fetch_busy;
  logic        exc_d;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_known = 0;
  bit          m_live  = 0;
  logic [31:0] m_pc, m_pcd, m_ins;
  logic        m_v, m_exc;
  int          busy_cnt;

  stage_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .next_pc    (next_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc_f       (pc_f),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .valid_d    (valid_d),
    .fetch_busy (fetch_busy),
    .exc_d      (exc_d)
  );

  assign imem_rdata = imem_addr ^ KEY;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef FETCH_EXC_EN
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st,
                      input logic rdy, input logic [31:0] npc);
    bit ill;
    bit rdy_eff;
    reset_n    = rst;
    stall      = st;
    imem_ready = rdy;
    next_pc    = npc;
    ill        = m_live && bad_addr(m_pc);
    rdy_eff    = ill || rdy;
    #1;
    if (m_known) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_live && !ill});
      chk("fetch_busy", {31'b0, fetch_busy},
          {31'b0, m_live && !rdy_eff});
      if (fetch_busy === 1'b1) busy_cnt++;
    end
    @(posedge clk);
    if (!rst) begin
      m_known = 1;
      m_live  = 0;
      m_pc    = RST_PC;
      m_pcd   = 32'h0;
      m_ins   = 32'h0;
      m_v     = 1'b0;
      m_exc   = 1'b0;
    end else if (!m_live) begin
      m_live = 1;
    end else if (rdy_eff && !st) begin
      m_pcd = m_pc;
      m_ins = ill ? 32'h0 : (m_pc ^ KEY);
      m_v   = 1'b1;
      m_exc = ill;
      m_pc  = npc;
    end
    #1;
    if (m_known) begin
      chk("pc_f", pc_f, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_d", pc_d, m_pcd);
      chk("instr_d", instr_d, m_ins);
      chk("valid_d", {31'b0, valid_d}, {31'b0, m_v});
      chk("exc_d", {31'b0, exc_d}, {31'b0, m_exc});
    end
  endtask

  initial begin
    logic [31:0] npc;
    reset_n    = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    next_pc    = 32'h0;
    busy_cnt   = 0;

    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0);
    step(1, 0, 1, 32'h0);
    chk("release_pc", pc_f, 32'h3000);
    chk("release_valid", {31'b0, valid_d}, 32'h0);

    step(1, 0, 1, m_pc + 4);
    chk("seq0", instr_d, 32'h3000 ^ KEY);
    step(1, 0, 1, m_pc + 4);
    chk("seq1", instr_d, 32'h3004 ^ KEY);
    step(1, 1, 1, m_pc + 4);
    step(1, 1, 1, m_pc + 4);
    chk("stall_pc", pc_f, 32'h3008);
    chk("stall_instr", instr_d, 32'h3004 ^ KEY);
    step(1, 0, 1, m_pc + 4);
    chk("resume", instr_d, 32'h3008 ^ KEY);

    busy_cnt = 0;
    repeat (3) step(1, 0, 0, m_pc + 4);
    chk("busy_cycles", busy_cnt, 3);
    chk("wait_hold", instr_d, 32'h3008 ^ KEY);
    step(1, 0, 1, m_pc + 4);
    chk("wait_done", instr_d, 32'h300C ^ KEY);

    step(1, 0, 1, 32'h3100);
    chk("delay_slot", instr_d, 32'h3010 ^ KEY);
    step(1, 0, 1, m_pc + 4);
    chk("jump_tgt", instr_d, 32'h3100 ^ KEY);

    step(1, 0, 0, m_pc + 4);
    step(0, 0, 1, m_pc + 4);
    step(1, 0, 1, 32'h0);
    chk("rst_wait_pc", pc_f, 32'h3000);
    chk("rst_wait_v", {31'b0, valid_d}, 32'h0);

`ifdef FETCH_EXC_EN
    step(1, 0, 1, 32'h3002);
    step(1, 0, 0, 32'h3004);
    chk("exc_mis", {31'b0, exc_d}, 32'h1);
    chk("exc_mis_nop", instr_d, 32'h0);
    step(1, 0, 1, 32'h7000);
    step(1, 0, 0, 32'h3000);
    chk("exc_oob", {31'b0, exc_d}, 32'h1);
    chk("exc_oob_nop", instr_d, 32'h0);
`endif

    for (int i = 0; i < 500; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) npc = m_pc + 4;
      else if (sel < 9) npc = BASE + 4 * $urandom_range(0, 4095);
      else npc = $urandom;
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0),
           npc);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Front-end pipeline stage that owns the program counter and the fetch/decode pipeline register. Each cycle it presents the current PC to the instruction memory and latches the returned word into the decode-side register. It also loads the next PC that the decode stage computes from the current fetch PC, which implements MIPS branch-delay-slot semantics. It stalls on a hazard-unit request or on a slow instruction memory, and it reports memory-wait cycles so the hazard unit can bubble the decode/execute boundary.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `IMEM_BASE`, 32'h0000_3000, lowest legal instruction address.
- `IMEM_WORDS`, 4096, number of legal instruction words starting at `IMEM_BASE`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: one clock; reset is synchronous and active-low.
- `stall` in 1: hazard-unit hold request; freeze PC and the decode register.
- `next_pc` in 32: next PC computed by decode from `pc_f` and `instr_d`.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, equal to `pc_f`.
- `imem_rdata` in 32: instruction word, valid when `imem_ready`=1.
- `imem_ready` in 1: memory response available this cycle; may be combinational on `imem_req`.
- `pc_f` out 32: current fetch PC, fed to decode as its PC operand.
- `pc_d` out 32: PC of the instruction held in decode.
- `instr_d` out 32: instruction held in decode.
- `valid_d` out 1: `instr_d` is a real instruction, not a bubble.
- `fetch_busy` out 1: memory wait is in progress; the hazard unit must bubble D/E.
- `exc_d` out 1: fetch exception on `pc_d` (only when `FETCH_EXC_EN` is defined).

## Operation
- State machine has three states:
  - RST: entered while `reset_n`=0.
  - RUN: normal fetch.
  - WAIT: request issued, `imem_ready` low.
- Reset state, taken at the clock edge while `reset_n`=0:
  - `pc_f`=`RESET_PC`, `pc_d`=0, `instr_d`=0, `valid_d`=0, `exc_d`=0.
  - State is RST. `imem_req`=0 and `fetch_busy`=0 while in RST.
- RST → RUN on the first edge with `reset_n`=1. No fetch is issued during that cycle.
- In RUN and WAIT, `imem_req`=1 (subject to Configuration).
- Advance condition: `adv` = `imem_ready` & !`stall` & state≠RST.
  - On `adv`: `pc_d`←`pc_f`, `instr_d`←`imem_rdata`, `valid_d`←1, `pc_f`←`next_pc`. State becomes RUN.
- If `imem_ready`=0 in RUN or WAIT: go to (or stay in) WAIT. Hold `pc_f`, `pc_d`, `instr_d` and `valid_d`. Assert `fetch_busy`=1 combinationally.
  - Freezing decode keeps a branch in decode until its delay slot arrives, so a redirect is never lost.
- If `stall`=1: hold all registers, and discard `imem_rdata` for that cycle. The same `pc_f` is re-requested next cycle.
- Precedence: `reset_n`=0 > `imem_ready`=0 hold > `stall` hold > advance.
- `next_pc` is sampled only on `adv`. Its value at any other time is ignored.
- Arithmetic: the fetch stage has no adder. All PC arithmetic is done in decode. PC wrap at 32'hFFFF_FFFC → 0 follows from `next_pc` unchanged.
- A reset asserted mid-WAIT abandons the outstanding request. A late `imem_ready` arriving in RST is ignored.

## Timing
- Fetch→decode latency: one cycle. A word returned in cycle N appears on `instr_d` in cycle N+1.
- Throughput: one instruction per cycle with `imem_ready` held at 1 and `stall`=0.
- `imem_addr`, `pc_f` and the `*_d` outputs are registered. `imem_req` and `fetch_busy` are decoded from the state register and `imem_ready` only. There is no combinational path from `stall` or `next_pc` to any output.
- When `stall` and `imem_ready`=0 occur together, `fetch_busy`=1 and the state is WAIT.

## Configuration
- `FETCH_EXC_EN` defined:
  - A fetch is illegal when `pc_f[1:0]`≠0 or `pc_f` lies outside [`IMEM_BASE`, `IMEM_BASE`+4·`IMEM_WORDS`).
  - For an illegal fetch, `imem_req`=0 and the memory is treated as ready.
  - On `adv` for an illegal fetch: `instr_d`←0 (nop), `valid_d`←1, `exc_d`←1.
  - `exc_d`←0 on every legal advance.
- `FETCH_EXC_EN` undefined:
  - `exc_d` is tied to 0 and no address check is made.
  - `imem_req`=1 in RUN/WAIT regardless of `pc_f`.

## Test plan
- Reset then run with `imem_ready`=1, memory returning `{addr}`, and decode feeding `next_pc`=`pc_f`+4 → `instr_d` sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, starting the second cycle after release.
- `stall`=1 for 2 cycles while `pc_f`=0x3008 → `pc_f`, `pc_d` and `instr_d` are frozen for 2 cycles, then the sequence resumes with 0x3008 and no instruction is skipped.
- Hold `imem_ready`=0 for 3 cycles at `pc_f`=0x300C → `fetch_busy`=1 for exactly 3 cycles, `instr_d` is held, then 0x300C latches on the fourth cycle.
- Jump in decode with `next_pc`=0x3100 while the delay slot at 0x3010 is being fetched → `instr_d` shows 0x3010 and then 0x3100.
- Assert `reset_n`=0 during WAIT, then release → `pc_f`=0x3000, `valid_d`=0, and the late `imem_ready` is ignored.
- With `FETCH_EXC_EN`, `next_pc`=0x3002 → `imem_req`=0; the next cycle has `exc_d`=1 and `instr_d`=0. Repeat with `next_pc`=0x7000 and expect the same response.
